// File: rtl/craft_inv_round_constants.sv
// CRAFT decryption round-constant sequencer: steps the a/b LFSRs backwards from round ROUNDS-1 to 0.
// Optional self-check of each step against a shadow of the previous state: define CRAFT_INV_RC_CHECK_EN.
module craft_inv_round_constants #(
    parameter int         ROUNDS = 32,
    parameter logic [3:0] A_INIT = 4'h8,
    parameter logic [2:0] B_INIT = 3'h5,
    localparam int        RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rc_ready,
    output logic [7:0]    rc,
    output logic          rc_valid,
    output logic [RW-1:0] rc_round,
    output logic          rc_last,
    output logic          done,
    output logic          rc_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [RW-1:0] ROUND_MAX = RW'(ROUNDS - 1);

    state_e        state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [2:0]    b_q, b_d;
    logic [RW-1:0] round_q, round_d;
    logic          step;

    // A step happens only on an accepted handshake that is not at round 0 and not overridden by start.
    assign step = (state_q == RUN) && rc_ready && !start && (round_q != '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        round_d = round_q;
        if (start) begin
            state_d = RUN;
            a_d     = A_INIT;
            b_d     = B_INIT;
            round_d = ROUND_MAX;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (rc_ready && round_q == '0) begin
                        state_d = DONE;
                    end else if (step) begin
                        a_d     = {a_q[2], a_q[1], a_q[0], a_q[3] ^ a_q[0]};
                        b_d     = {b_q[1], b_q[0], b_q[2] ^ b_q[0]};
                        round_d = round_q - 1'b1;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= A_INIT;
            b_q     <= B_INIT;
            round_q <= ROUND_MAX;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            round_q <= round_d;
        end
    end

    assign rc       = {a_q, 1'b0, b_q};
    assign rc_valid = (state_q == RUN);
    assign rc_round = round_q;
    assign rc_last  = rc_valid && (round_q == '0);
    assign done     = (state_q == DONE);

`ifdef CRAFT_INV_RC_CHECK_EN
    logic [6:0] shadow_q;
    logic       pending_q;
    logic       err_q;
    logic [6:0] fwd_ab;

    // Forward step of the current state must reproduce the state emitted just before it.
    assign fwd_ab = {a_q[1] ^ a_q[0], a_q[3:1], b_q[1] ^ b_q[0], b_q[2:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (start) begin
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= step;
            if (step) begin
                shadow_q <= {a_q, b_q};
            end
            if (pending_q && (fwd_ab != shadow_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rc_err = err_q;
`else
    assign rc_err = 1'b0;
`endif

endmodule

// File: tb/tb_craft_inv_round_constants.sv
// Directed bench for craft_inv_round_constants: sequence, backpressure, restart, async reset.
module tb_craft_inv_round_constants;

    localparam int RW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          rc_ready;
    logic [7:0]    rc;
    logic          rc_valid;
    logic [RW-1:0] rc_round;
    logic          rc_last;
    logic          done;
    logic          rc_err;

    int checks;
    int errors;

    logic [7:0] exp_rc [32];
    logic [7:0] got_rc [32];
    int         accepts;

    craft_inv_round_constants dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rc_ready (rc_ready),
        .rc       (rc),
        .rc_valid (rc_valid),
        .rc_round (rc_round),
        .rc_last  (rc_last),
        .done     (done),
        .rc_err   (rc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        rc_ready = 1'b1;
        while (int'(rc_round) != target && n < 64) begin
            tick();
            n++;
        end
        rc_ready = 1'b0;
        if (n >= 64) check("run_to_timeout", 32'(rc_round), 32'(target));
    endtask

    // Forward model: a'={a1^a0,a[3:1]}, b'={b1^b0,b[2:1]} from {1,1} at round 0.
    task automatic build_model();
        logic [3:0] a;
        logic [2:0] b;
        a = 4'h1;
        b = 3'h1;
        for (int r = 0; r < 32; r++) begin
            exp_rc[r] = {a, 1'b0, b};
            a = {a[1] ^ a[0], a[3:1]};
            b = {b[1] ^ b[0], b[2:1]};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        accepts  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        rc_ready = 1'b0;
        build_model();

        // Reset values
        tick();
        check("rst_valid", 32'(rc_valid), 32'd0);
        check("rst_rc", 32'(rc), 32'h85);
        check("rst_round", 32'(rc_round), 32'd31);
        check("rst_last", 32'(rc_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(rc_err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(rc_valid), 32'd0);

        // Full run with rc_ready held high
        pulse_start();
        check("start_valid", 32'(rc_valid), 32'd1);
        rc_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!rc_valid) break;
            if (accepts < 32) got_rc[accepts] = rc;
            check("last_flag", 32'(rc_last), 32'(rc_round == 0));
            case (rc_round)
                5'd31: check("rc_r31", 32'(rc), 32'h85);
                5'd30: check("rc_r30", 32'(rc), 32'h12);
                5'd29: check("rc_r29", 32'(rc), 32'h34);
                5'd3:  check("rc_r3", 32'(rc), 32'h25);
                5'd1:  check("rc_r1", 32'(rc), 32'h84);
                5'd0:  check("rc_r0", 32'(rc), 32'h11);
                default: ;
            endcase
            accepts++;
            tick();
        end
        rc_ready = 1'b0;
        check("accepts", 32'(accepts), 32'd32);
        check("done_after_run", 32'(done), 32'd1);
        check("valid_after_run", 32'(rc_valid), 32'd0);
        check("err_after_run", 32'(rc_err), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check("seq_vs_model", 32'(got_rc[i]), 32'(exp_rc[31 - i]));
        end
        repeat (3) tick();
        check("done_held", 32'(done), 32'd1);

        // Backpressure at round 30
        pulse_start();
        check("bp_done_clr", 32'(done), 32'd0);
        check("bp_r31", 32'(rc), 32'h85);
        rc_ready = 1'b1;
        tick();
        rc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rc_hold", 32'(rc), 32'h12);
            check("bp_round_hold", 32'(rc_round), 32'd30);
        end
        rc_ready = 1'b1;
        tick();
        rc_ready = 1'b0;
        check("bp_resume_rc", 32'(rc), 32'h34);
        check("bp_resume_round", 32'(rc_round), 32'd29);

        // Restart at round 10 without handshake
        run_to(10);
        check("pre_restart_rc", 32'(rc), 32'(exp_rc[10]));
        pulse_start();
        check("restart_rc", 32'(rc), 32'h85);
        check("restart_round", 32'(rc_round), 32'd31);
        check("restart_done", 32'(done), 32'd0);
        check("restart_valid", 32'(rc_valid), 32'd1);

        // Start coincident with an accepted handshake
        run_to(20);
        rc_ready = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        rc_ready = 1'b0;
        check("coinc_rc", 32'(rc), 32'h85);
        check("coinc_round", 32'(rc_round), 32'd31);

        // Async reset mid-cycle at round 20
        run_to(20);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(rc_valid), 32'd0);
        check("arst_rc", 32'(rc), 32'h85);
        check("arst_done", 32'(done), 32'd0);
        check("arst_round", 32'(rc_round), 32'd31);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_arst_idle", 32'(rc_valid), 32'd0);
        check("post_arst_done", 32'(done), 32'd0);

`ifdef CRAFT_INV_RC_CHECK_EN
        // Corrupt the a-LFSR after a step: the shadow comparison must flag it and hold it.
        pulse_start();
        rc_ready = 1'b1;
        tick();
        tick();
        check("chk_clean", 32'(rc_err), 32'd0);
        force dut.a_q = dut.a_q ^ 4'h1;
        tick();
        release dut.a_q;
        rc_ready = 1'b0;
        tick();
        check("chk_err_set", 32'(rc_err), 32'd1);
        repeat (3) tick();
        check("chk_err_sticky", 32'(rc_err), 32'd1);
        pulse_start();
        check("chk_err_clr", 32'(rc_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
